// File: rtl/id_ex_alu_issue.sv
// ID/EX issue stage for the ALU: RV32I decode, operand select, load-use
// bubble insertion, EX stall/flush handling and a saturating bubble counter.
module id_ex_alu_issue #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [31:0]      id_instr,
    input  logic [XLEN-1:0]  id_rs1_data,
    input  logic [XLEN-1:0]  id_rs2_data,
    input  logic             stall_ex,
    input  logic             flush_ex,
    output logic             id_stall,
    output logic             ex_valid,
    output logic [XLEN-1:0]  ex_A,
    output logic [XLEN-1:0]  ex_B,
    output logic [2:0]       ex_ALUControl,
    output logic [XLEN-1:0]  ex_rs2_data,
    output logic [4:0]       ex_rd,
    output logic             ex_reg_write,
    output logic             ex_mem_read,
    output logic             ex_mem_write,
    output logic             ex_branch,
    output logic             ex_illegal,
    output logic [CNT_W-1:0] bubble_cnt
);

    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_I  = 7'b0010011;
    localparam logic [6:0] OP_LD = 7'b0000011;
    localparam logic [6:0] OP_ST = 7'b0100011;
    localparam logic [6:0] OP_BR = 7'b1100011;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b101;

    logic [6:0]      w_op;
    logic [2:0]      w_f3;
    logic            w_f7b;
    logic [4:0]      w_rd;
    logic [4:0]      w_rs1;
    logic [4:0]      w_rs2;
    logic [XLEN-1:0] w_imm_i;
    logic [XLEN-1:0] w_imm_s;
    logic [2:0]      w_alu;
    logic [XLEN-1:0] w_b;
    logic            w_rw;
    logic            w_mr;
    logic            w_mw;
    logic            w_br;
    logic            w_ill;
    logic            w_use_rs2;
    logic            w_haz;

    logic             r_valid;
    logic [XLEN-1:0]  r_a;
    logic [XLEN-1:0]  r_b;
    logic [2:0]       r_alu;
    logic [XLEN-1:0]  r_rs2;
    logic [4:0]       r_rd;
    logic             r_rw;
    logic             r_mr;
    logic             r_mw;
    logic             r_br;
    logic             r_ill;
    logic [CNT_W-1:0] r_cnt;

    assign w_op    = id_instr[6:0];
    assign w_f3    = id_instr[14:12];
    assign w_f7b   = id_instr[30];
    assign w_rd    = id_instr[11:7];
    assign w_rs1   = id_instr[19:15];
    assign w_rs2   = id_instr[24:20];
    assign w_imm_i = {{(XLEN-12){id_instr[31]}}, id_instr[31:20]};
    assign w_imm_s = {{(XLEN-12){id_instr[31]}}, id_instr[31:25], id_instr[11:7]};

    always_comb begin
        w_alu     = ALU_ADD;
        w_b       = id_rs2_data;
        w_rw      = 1'b0;
        w_mr      = 1'b0;
        w_mw      = 1'b0;
        w_br      = 1'b0;
        w_ill     = 1'b0;
        w_use_rs2 = 1'b0;
        case (w_op)
            OP_R: begin
                w_use_rs2 = 1'b1;
                w_rw      = 1'b1;
                case (w_f3)
                    3'b000:  w_alu = w_f7b ? ALU_SUB : ALU_ADD;
                    3'b111:  w_alu = ALU_AND;
                    3'b110:  w_alu = ALU_OR;
                    3'b100:  w_alu = ALU_XOR;
                    3'b010:  w_alu = ALU_SLT;
                    default: w_ill = 1'b1;
                endcase
            end
            OP_I: begin
                w_b  = w_imm_i;
                w_rw = 1'b1;
                case (w_f3)
                    3'b000:  w_alu = ALU_ADD;
                    3'b111:  w_alu = ALU_AND;
                    3'b110:  w_alu = ALU_OR;
                    3'b100:  w_alu = ALU_XOR;
                    3'b010:  w_alu = ALU_SLT;
                    default: w_ill = 1'b1;
                endcase
            end
            OP_LD: begin
                w_b  = w_imm_i;
                w_mr = 1'b1;
                w_rw = 1'b1;
            end
            OP_ST: begin
                w_use_rs2 = 1'b1;
                w_b       = w_imm_s;
                w_mw      = 1'b1;
            end
            OP_BR: begin
                w_use_rs2 = 1'b1;
                w_br      = 1'b1;
                case (w_f3)
                    3'b000, 3'b001: w_alu = ALU_SUB;
                    3'b100:         w_alu = ALU_SLT;
                    default:        w_ill = 1'b1;
                endcase
            end
            default: w_ill = 1'b1;
        endcase
        // Unsupported encodings must never produce side effects
        if (w_ill) begin
            w_alu = ALU_ADD;
            w_rw  = 1'b0;
            w_mr  = 1'b0;
            w_mw  = 1'b0;
            w_br  = 1'b0;
        end
        if (w_rd == 5'd0) w_rw = 1'b0;
    end

    assign w_haz = id_valid & r_valid & r_mr & (r_rd != 5'd0) &
                   ((r_rd == w_rs1) | ((r_rd == w_rs2) & w_use_rs2));
    assign id_stall = w_haz & ~flush_ex & ~stall_ex;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
            r_alu   <= ALU_ADD;
            r_rs2   <= '0;
            r_rd    <= '0;
            r_rw    <= 1'b0;
            r_mr    <= 1'b0;
            r_mw    <= 1'b0;
            r_br    <= 1'b0;
            r_ill   <= 1'b0;
            r_cnt   <= '0;
        end else if (flush_ex || !stall_ex) begin
            if (flush_ex || w_haz) begin
                r_valid <= 1'b0;
                r_a     <= '0;
                r_b     <= '0;
                r_alu   <= ALU_ADD;
                r_rs2   <= '0;
                r_rd    <= '0;
                r_rw    <= 1'b0;
                r_mr    <= 1'b0;
                r_mw    <= 1'b0;
                r_br    <= 1'b0;
                r_ill   <= 1'b0;
            end else begin
                r_valid <= id_valid;
                r_a     <= id_rs1_data;
                r_b     <= w_b;
                r_alu   <= w_alu;
                r_rs2   <= id_rs2_data;
                r_rd    <= w_rd;
                r_rw    <= w_rw & id_valid;
                r_mr    <= w_mr & id_valid;
                r_mw    <= w_mw & id_valid;
                r_br    <= w_br & id_valid;
                r_ill   <= w_ill & id_valid;
            end
            // Only load-use bubbles are counted, never flushes
            if (w_haz && !flush_ex && (r_cnt != '1))
                r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign ex_valid      = r_valid;
    assign ex_A          = r_a;
    assign ex_B          = r_b;
    assign ex_ALUControl = r_alu;
    assign ex_rs2_data   = r_rs2;
    assign ex_rd         = r_rd;
    assign ex_reg_write  = r_rw;
    assign ex_mem_read   = r_mr;
    assign ex_mem_write  = r_mw;
    assign ex_branch     = r_br;
    assign ex_illegal    = r_ill;
    assign bubble_cnt    = r_cnt;

endmodule
